// File: rtl/lutram_multi_port_init.sv
// Distributed (LUT) RAM with one write port, N_READ independent read ports,
// a post-reset clear sweep that loads INIT_VALUE into every entry, optional
// write-to-read bypass and optional registered read data.
//
// INIT is driven straight from the two-state sequencer register, so it is
// also the observable state of the FSM (0 = CLEAR, 1 = READY).
module lutram_multi_port_init #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    N_READ     = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    BYPASS     = 1,
  parameter int                    REG_OUT    = 0
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  output logic                             INIT,
  input  logic [ADDR_WIDTH-1:0]            ADDR_IN,
  input  logic [DATA_WIDTH-1:0]            D_IN,
  input  logic                             WE,
  input  logic [N_READ*ADDR_WIDTH-1:0]     ADDR_RD,
  output logic [N_READ*DATA_WIDTH-1:0]     D_OUT
);

  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;
  localparam bit                    BYP_EN   = (BYPASS != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clear_ptr_q;

  (* ram_style = "distributed" *)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Clear sequencer: restart the sweep on every reset edge, walk the pointer
  // through all entries, then park in READY until the next reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clear_ptr_q == LAST_PTR) begin
            state_q <= ST_READY;
          end else begin
            clear_ptr_q <= clear_ptr_q + ADDR_WIDTH'(1);
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  assign INIT = (state_q == ST_READY);

  // Single write port shared by the sweep and the user: during CLEAR the
  // sweep owns it and user writes are dropped; nothing is written on a
  // reset edge since the following sweep overwrites everything anyway.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ADDR_IN;
    mem_wdata = D_IN;
    if (RST_N) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clear_ptr_q;
        mem_wdata = INIT_VALUE;
      end else if (WE) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array: no reset, contents are defined by the clear sweep.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // One read path per port; synthesis replicates the array per read port.
  for (genvar i = 0; i < N_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    assign rd_addr = ADDR_RD[i*ADDR_WIDTH +: ADDR_WIDTH];

    // Array lookup, then same-cycle bypass, then INIT_VALUE forcing while
    // the sweep has not finished (contents are not meaningful yet).
    always_comb begin
      rd_data = mem_q[rd_addr];
      if (BYP_EN && INIT && WE && (rd_addr == ADDR_IN)) begin
        rd_data = D_IN;
      end
      if (!INIT) begin
        rd_data = INIT_VALUE;
      end
    end

    if (REG_OUT != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;

      // Registered read: capture this cycle's combinational read value.
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          dout_q <= INIT_VALUE;
        end else begin
          dout_q <= rd_data;
        end
      end

      assign D_OUT[i*DATA_WIDTH +: DATA_WIDTH] = dout_q;
    end else begin : g_comb
      assign D_OUT[i*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    end
  end

endmodule

// File: doc/lutram_multi_port_init.md
Name: lutram_multi_port_init

Overview:
- Parametrised LUT-based (distributed) RAM with one write port and N independent asynchronous or registered read ports.
- Adds a hardware clear sequencer that writes INIT_VALUE to every entry after reset; completion is signalled on INIT.
- Adds optional write-to-read bypass.
- Used as the storage core for small multi-reader tables (scoreboards, rename maps, FIFO bodies) where the single-read, initial-block-only RAM is insufficient.

Parameters:
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries (legal 1..10).
- DATA_WIDTH, 32, bits per entry (legal >= 1).
- N_READ, 2, number of read ports (legal 1..8).
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every entry by the clear sequencer.
- BYPASS, 1, 1 = read of the address being written in the same cycle returns D_IN; 0 = returns old contents.
- REG_OUT, 0, 0 = combinational read (latency 0); 1 = registered read (latency 1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- INIT  out  1  high when the clear sequence is complete and the RAM is usable.
- ADDR_IN  in  ADDR_WIDTH  write address.
- D_IN  in  DATA_WIDTH  write data.
- WE  in  1  write enable; honoured only while INIT=1.
- ADDR_RD  in  N_READ*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- D_OUT  out  N_READ*DATA_WIDTH  read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset is sampled only on the rising CLK edge with RST_N=0. Every edge with RST_N=0 sets state=CLEAR, clear_ptr=0, INIT=0, and, if REG_OUT=1, all D_OUT registers to INIT_VALUE. Array contents are not touched by reset itself.
- State machine has two states:
  - CLEAR: on each edge with RST_N=1, write arr[clear_ptr] <= INIT_VALUE. If clear_ptr == DEPTH-1, go to READY and set INIT=1; otherwise clear_ptr++. CLEAR therefore lasts exactly DEPTH cycles after the first edge with RST_N=1.
  - READY: terminal until the next reset. INIT=1.
- Reset mid-CLEAR or in READY restarts the sequence at clear_ptr=0. Partially cleared or old contents are overwritten by the full sweep.
- Write: in READY, on each edge with WE=1, arr[ADDR_IN] <= D_IN. WE in CLEAR is ignored: no write, no queuing.
- Read with REG_OUT=0:
  - D_OUT[i] = arr[ADDR_RD[i]] combinationally.
  - If BYPASS=1, INIT=1, WE=1 and ADDR_RD[i]==ADDR_IN, D_OUT[i] = D_IN.
  - While INIT=0, D_OUT[i] = INIT_VALUE regardless of address.
- Read with REG_OUT=1:
  - Each edge, D_OUT[i] <= the same value the REG_OUT=0 path would present that cycle, including bypass and the INIT=0 forcing.
  - Latency is 1 cycle from ADDR_RD.
- Read ports are fully independent. Any number of ports may read the same address in one cycle, and all see identical data.
- Write data becomes visible to non-bypassed reads the cycle after the write edge.
- ADDR_IN and ADDR_RD are always in range because DEPTH is a power of two; no range checks.
- Array is inferred as distributed RAM (ram_style distributed), one write port replicated per read port.
- No simulation initial block is required for correctness; the clear sequencer defines contents.

Test Plan:
- Reset clear: ADDR_WIDTH=5, hold RST_N=0 for 3 cycles, then release -> INIT=0 for exactly 32 cycles, INIT=1 on cycle 32. Read all 32 addresses on both ports -> every value is 0x00000000 (INIT_VALUE). Repeat with INIT_VALUE=0xDEADBEEF -> all reads return 0xDEADBEEF.
- Write/read: in READY, write 0x12345678 to addr 7 and 0xA5A5A5A5 to addr 31. Next cycle, port0 reads 7 and port1 reads 31 -> 0x12345678 and 0xA5A5A5A5 simultaneously.
- Bypass: BYPASS=1, REG_OUT=0, WE=1, ADDR_IN=4, D_IN=0x55, ADDR_RD0=4 in the same cycle -> D_OUT0=0x55 that cycle. With BYPASS=0 -> old value that cycle, 0x55 the next cycle.
- Write during clear: WE=1, ADDR_IN=3, D_IN=0xFF pulsed 5 cycles after reset release -> after INIT=1, addr 3 reads INIT_VALUE. D_OUT equals INIT_VALUE throughout CLEAR for any address.
- Reset mid-operation: write 0x99 to addr 10 in READY, then assert RST_N=0 for 1 cycle; separately assert reset again 12 cycles into CLEAR -> INIT stays 0 for 32 cycles after the final release, and addr 10 reads INIT_VALUE.
- Registered output: REG_OUT=1, write 0x42 to addr 2, then drive ADDR_RD1=2 at cycle t -> D_OUT1=0x42 at t+1, and not before. Reset -> D_OUT registers equal INIT_VALUE on the next edge.
